// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one fixed-latency fp16 multiplier among NREQ requesters, with a credit-limited response FIFO.
// Optional build macro FP16_ARB_FIXED_PRI_EN gives requester 0 absolute priority over the round-robin.
module fp16_mul_arbiter #(
    parameter int NREQ      = 4,
    parameter int MUL_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [16*NREQ-1:0]      req_a,
    input  logic [16*NREQ-1:0]      req_b,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    input  logic [15:0]             mul_p,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             rsp_data,
    output logic                    busy
);
    localparam int ID_W = $clog2(NREQ);
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW   = $clog2(RSP_DEPTH + MUL_LAT + 1) + 1;

    logic [ID_W-1:0]    last_grant_r;
    logic [MUL_LAT-1:0] tag_v_r;
    logic [ID_W-1:0]    tag_id_r [MUL_LAT];
    logic [ID_W+15:0]   mem_r [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      fifo_cnt_r;

    logic [CW-1:0]      inflight_s;
    logic               credit_ok_s;
    logic               found_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [NREQ-1:0]    grant_s;
    logic               upd_lg_s;
    logic               push_s;
    logic               pop_s;
    logic [ID_W+15:0]   head_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Count ops still travelling through the multiplier.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight_s = inflight_s + CW'(tag_v_r[i]);
        end
    end

    // A pop in this cycle only frees its credit once the count register drops.
    assign credit_ok_s = ((fifo_cnt_r + inflight_s) < CW'(RSP_DEPTH)) && !RESET;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx_v;
        found_s     = 1'b0;
        grant_idx_s = '0;
        idx_v       = 0;
        if (credit_ok_s) begin
`ifdef FP16_ARB_FIXED_PRI_EN
            if (req_valid[0]) begin
                found_s = 1'b1;
            end else begin
`endif
                for (int k = 1; k <= NREQ; k++) begin
                    idx_v = (int'(last_grant_r) + k) % NREQ;
                    if (!found_s && req_valid[ID_W'(idx_v)]) begin
                        found_s     = 1'b1;
                        grant_idx_s = ID_W'(idx_v);
                    end else begin
                        found_s = found_s;
                    end
                end
`ifdef FP16_ARB_FIXED_PRI_EN
            end
`endif
        end else begin
            found_s = 1'b0;
        end
    end

    // One-hot grant and operand mux for the issue cycle.
    always_comb begin
        grant_s = '0;
        mul_a   = 16'h0000;
        mul_b   = 16'h0000;
        if (found_s) begin
            grant_s[grant_idx_s] = 1'b1;
            mul_a = req_a[16*grant_idx_s +: 16];
            mul_b = req_b[16*grant_idx_s +: 16];
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready = grant_s;

`ifdef FP16_ARB_FIXED_PRI_EN
    // Priority grants to requester 0 leave the rotation untouched.
    assign upd_lg_s = found_s && (grant_idx_s != '0);
`else
    assign upd_lg_s = found_s;
`endif

    // Round-robin pointer, moved only by a transfer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant_r <= ID_W'(NREQ - 1);
        end else if (upd_lg_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Tag pipe carrying {valid, requester id} alongside the multiplier.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tag_v_r <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= found_s;
            tag_id_r[0] <= grant_idx_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    assign push_s = tag_v_r[MUL_LAT-1];
    assign pop_s  = rsp_valid && rsp_ready;

    // Response FIFO: circular buffer with occupancy counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {tag_id_r[MUL_LAT-1], mul_p};
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign head_s    = mem_r[rd_ptr_r];
    assign rsp_valid = (fifo_cnt_r != '0);
    assign rsp_id    = rsp_valid ? head_s[ID_W+15:16] : '0;
    assign rsp_data  = rsp_valid ? head_s[15:0] : 16'h0000;
    assign busy      = (inflight_s != '0) || rsp_valid;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter: vector table for single ops plus sequences for arbitration, backpressure and reset.
module tb_fp16_mul_arbiter;
    localparam int NREQ      = 4;
    localparam int MUL_LAT   = 1;
    localparam int RSP_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    always #5 CLK = ~CLK;

    fp16_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    // Shared multiplier stand-in: normal numbers only, truncating.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] ma;
        logic [21:0] mb;
        logic [21:0] m;
        logic [9:0]  fr;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0000};
        ma = {11'd0, 1'b1, a[9:0]};
        mb = {11'd0, 1'b1, b[9:0]};
        m  = ma * mb;
        e  = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (m[21]) begin
            fr = m[20:11];
            e  = e + 1;
        end else begin
            fr = m[19:10];
        end
        return {s, e[4:0], fr};
    endfunction

    logic [15:0] mpipe [MUL_LAT];
    always @(posedge CLK) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[MUL_LAT-1];

    typedef struct {
        int          rid;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t        vec [5];
    logic [15:0] rr_b [4];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  got_id [$];
    logic [15:0] got_data [$];
    logic [1:0]  exp_id [$];
    logic [15:0] exp_data [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // Record a response handshake in the current cycle, then move to the next cycle.
    task automatic adv();
        if (rsp_valid && rsp_ready) begin
            got_id.push_back(rsp_id);
            got_data.push_back(rsp_data);
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        got_id.delete();
        got_data.delete();
    endtask

    task automatic drain();
        bit done;
        done      = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!busy && !rsp_valid) done = 1'b1;
            else adv();
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
        @(negedge CLK);
    endtask

    task automatic chk_rsp(input string name);
        chk({name, "_count"}, got_id.size(), exp_id.size());
        for (int i = 0; i < exp_id.size() && i < got_id.size(); i++) begin
            chk($sformatf("%s_id%0d", name, i), got_id[i], exp_id[i]);
            chk($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        end
        exp_id.delete();
        exp_data.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = '{0, 16'h3E00, 16'h4000, 16'h4200};
        vec[1] = '{2, 16'hBC00, 16'h4000, 16'hC000};
        vec[2] = '{1, 16'h3C00, 16'h3C00, 16'h3C00};
        vec[3] = '{3, 16'h4400, 16'h4200, 16'h4A00};
        vec[4] = '{1, 16'h3C00, 16'h0000, 16'h0000};
        rr_b[0] = 16'h3C00;
        rr_b[1] = 16'h4000;
        rr_b[2] = 16'h4200;
        rr_b[3] = 16'h4400;

        req_valid = 4'h0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        rsp_ready = 1'b1;
        RESET     = 1'b1;
        @(negedge CLK);
        #1;
        chk("rst_req_ready", req_ready, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_id", rsp_id, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Single-op vectors: issue, latency of two cycles, empty afterwards.
        for (int v = 0; v < 5; v++) begin
            set_req(vec[v].rid, vec[v].a, vec[v].b);
            req_valid = 4'b0001 << vec[v].rid;
            #1;
            chk($sformatf("v%0d_ready", v), req_ready, 32'd1 << vec[v].rid);
            chk($sformatf("v%0d_mul_a", v), mul_a, vec[v].a);
            chk($sformatf("v%0d_mul_b", v), mul_b, vec[v].b);
            @(negedge CLK);
            req_valid = 4'h0;
            #1;
            chk($sformatf("v%0d_early_valid", v), rsp_valid, 32'd0);
            chk($sformatf("v%0d_busy_inflight", v), busy, 32'd1);
            @(negedge CLK);
            #1;
            chk($sformatf("v%0d_rsp_valid", v), rsp_valid, 32'd1);
            chk($sformatf("v%0d_rsp_id", v), rsp_id, vec[v].rid);
            chk($sformatf("v%0d_rsp_data", v), rsp_data, vec[v].p);
            @(negedge CLK);
            #1;
            chk($sformatf("v%0d_empty", v), rsp_valid, 32'd0);
            chk($sformatf("v%0d_idle", v), busy, 32'd0);
            @(negedge CLK);
        end

        // Round-robin with every requester valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'h3C00, rr_b[i]);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_grant%0d", c), req_ready, 32'd1 << (c % 4));
            adv();
            exp_id.push_back(2'(c % 4));
            exp_data.push_back(rr_b[c % 4]);
        end
        drain();
        chk_rsp("rr");

        // Backpressure: four credits, then a single pop frees one grant.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp_grant%0d", c), req_ready, 32'd1 << c);
            adv();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("bp_stall%0d", c), req_ready, 32'd0);
            chk($sformatf("bp_valid%0d", c), rsp_valid, 32'd1);
            adv();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_ready", req_ready, 32'd0);
        adv();
        rsp_ready = 1'b0;
        #1;
        chk("bp_regrant", req_ready, 32'd1);
        adv();
        #1;
        chk("bp_restall", req_ready, 32'd0);
        adv();
        drain();
        for (int i = 0; i < 5; i++) begin
            exp_id.push_back(2'(i % 4));
            exp_data.push_back(rr_b[i % 4]);
        end
        chk_rsp("bp");

        // Sign and issue ordering across requesters.
        do_reset();
        set_req(2, 16'hBC00, 16'h4000);
        req_valid = 4'b0100;
        #1;
        chk("ord_grant2", req_ready, 32'h4);
        adv();
        set_req(1, 16'h3C00, 16'h3C00);
        req_valid = 4'b0010;
        #1;
        chk("ord_grant1", req_ready, 32'h2);
        adv();
        drain();
        exp_id.push_back(2'd2);
        exp_data.push_back(16'hC000);
        exp_id.push_back(2'd1);
        exp_data.push_back(16'h3C00);
        chk_rsp("ord");

        // Reset with ops in flight and in the FIFO.
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'h3C00, rr_b[i]);
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            adv();
        end
        #1;
        chk("mid_busy_pre", busy, 32'd1);
        chk("mid_valid_pre", rsp_valid, 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid_req_ready", req_ready, 32'd0);
        chk("mid_mul_a", mul_a, 32'd0);
        chk("mid_rsp_valid", rsp_valid, 32'd0);
        chk("mid_rsp_id", rsp_id, 32'd0);
        chk("mid_rsp_data", rsp_data, 32'd0);
        chk("mid_busy", busy, 32'd0);
        @(negedge CLK);
        RESET     = 1'b0;
        rsp_ready = 1'b1;
        got_id.delete();
        got_data.delete();
        #1;
        chk("mid_first_grant", req_ready, 32'd1);
        adv();
        drain();
        exp_id.push_back(2'd0);
        exp_data.push_back(16'h3C00);
        chk_rsp("mid");

`ifdef FP16_ARB_FIXED_PRI_EN
        // Requester 0 starves requester 3 until it drops valid.
        do_reset();
        set_req(0, 16'h3C00, 16'h3C00);
        set_req(3, 16'h3C00, 16'h4400);
        req_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("fp_grant0_%0d", c), req_ready, 32'd1);
            adv();
        end
        req_valid = 4'b1000;
        #1;
        chk("fp_grant3", req_ready, 32'h8);
        adv();
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
